// File: rtl/sound_pkg.sv
// Shared definitions for the sound card mixer and DAC back end.
// Register indices, mixer state encoding and a width helper.
package sound_pkg;

  localparam logic [7:0] IDX_CTRL   = 8'h10;
  localparam logic [7:0] IDX_STATUS = 8'h11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_SAT
  } mix_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order delta-sigma 1-bit DAC.
// Signed input is offset to binary and integrated; the carry is the bit.
module sigma_delta_dac #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] din,
  output logic                dout
);

  logic [SAMPLE_W:0]   acc_q, acc_d;
  logic                dout_q, dout_d;
  logic [SAMPLE_W-1:0] u;

  // Offset-binary conversion and integrator step.
  always_comb begin
    u      = {~din[SAMPLE_W-1], din[SAMPLE_W-2:0]};
    acc_d  = {1'b0, acc_q[SAMPLE_W-1:0]} + {1'b0, u};
    dout_d = acc_q[SAMPLE_W];
  end

  // Integrator and output bit registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/sound_mix_dac.sv
// Multi-channel volume mixer with saturation and 1-bit DAC output.
// ISA index/data register window for volumes, mute and sticky status.
module sound_mix_dac
  import sound_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          SAMPLE_W = 16,
  parameter int          VOL_W    = 8,
  parameter logic [15:0] IO_BASE  = 16'h038A
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [19:0]                bus_a,
  input  logic                       bus_ior_l,
  input  logic                       bus_iow_l,
  input  logic                       bus_aen,
  input  logic [7:0]                 bus_d,
  output logic [7:0]                 bus_out,
  output logic                       bus_dir,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_in,
  input  logic                       sample_stb,
  output logic [SAMPLE_W-1:0]        mix_out,
  output logic                       mix_valid,
  output logic                       dac_out
);

  localparam int CH_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int ACC_W  = SAMPLE_W + VOL_W + clog2(NUM_CH) + 1;
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;
  localparam logic [15:0] IO_IDX = IO_BASE;
  localparam logic [15:0] IO_DAT = IO_BASE + 16'd1;
  localparam logic [VOL_W-1:0] VOL_UNITY = VOL_W'(1) << (VOL_W - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Bus synchroniser state.
  logic ior_q, ior_d;
  logic iow_q, iow_d;
  logic iowp_q, iowp_d;

  // Register file.
  logic [7:0]       idx_q, idx_d;
  logic [VOL_W-1:0] vol_q [NUM_CH];
  logic [VOL_W-1:0] vol_d [NUM_CH];
  logic             mute_q, mute_d;
  logic             clip_q, clip_d;
  logic             ovr_q, ovr_d;

  // Mixer datapath.
  mix_state_e                 state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [NUM_CH*SAMPLE_W-1:0] buf_q, buf_d;
  logic [SAMPLE_W-1:0]        mix_q, mix_d;
  logic                       valid_q, valid_d;

  logic [15:0] a16;
  logic        unused_a;
  logic        hit_idx, hit_dat;
  logic        wr_stb, clr_flags;
  logic [7:0]  dat_rd;

  logic signed [SAMPLE_W-1:0] samp;
  logic signed [PROD_W-1:0]   prod, prod_sh;
  logic signed [ACC_W-1:0]    term;

  assign a16      = bus_a[15:0];
  assign unused_a = ^bus_a[19:16];
  assign hit_idx  = ~bus_aen && (a16 == IO_IDX);
  assign hit_dat  = ~bus_aen && (a16 == IO_DAT);
  assign wr_stb   = ~iow_q & iowp_q;

  // Single-stage capture of the asynchronous strobes.
  always_comb begin
    ior_d  = bus_ior_l;
    iow_d  = bus_iow_l;
    iowp_d = iow_q;
  end

  // Register writes: one commit on the first synced low of iow.
  always_comb begin
    idx_d     = idx_q;
    vol_d     = vol_q;
    mute_d    = mute_q;
    clr_flags = 1'b0;
    if (wr_stb && hit_idx) begin
      idx_d = bus_d;
    end
    if (wr_stb && hit_dat) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (idx_q == 8'(i)) vol_d[i] = VOL_W'(bus_d);
      end
      if (idx_q == IDX_CTRL) begin
        mute_d    = bus_d[0];
        clr_flags = bus_d[1];
      end
    end
  end

  // Data-port read mux; unmapped indices read all ones.
  always_comb begin
    dat_rd = 8'hFF;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == 8'(i)) dat_rd = 8'(vol_q[i]);
    end
    unique case (1'b1)
      (idx_q == IDX_CTRL):   dat_rd = {7'b0, mute_q};
      (idx_q == IDX_STATUS): dat_rd = {6'b0, ovr_q, clip_q};
      default: ;
    endcase
  end

  assign bus_dir = ~ior_q & (hit_idx | hit_dat);
  assign bus_out = bus_dir ? (hit_idx ? idx_q : dat_rd) : 8'h00;

  // Scaled contribution of the channel selected this cycle.
  always_comb begin
    samp    = $signed(buf_q[ch_q*SAMPLE_W +: SAMPLE_W]);
    prod    = PROD_W'(samp) * PROD_W'($signed({1'b0, vol_q[ch_q]}));
    prod_sh = prod >>> (VOL_W - 1);
    term    = ACC_W'(prod_sh);
  end

  // Mixer FSM: latch, accumulate per channel, saturate and publish.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    buf_d   = buf_q;
    mix_d   = mix_q;
    valid_d = 1'b0;
    clip_d  = clip_q;
    ovr_d   = ovr_q;
    if (clr_flags) begin
      clip_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (sample_stb && state_q != ST_IDLE) ovr_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (sample_stb) begin
          buf_d   = ch_in;
          acc_d   = '0;
          ch_d    = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        acc_d = acc_q + term;
        if (ch_q == CH_W'(NUM_CH - 1)) state_d = ST_SAT;
        else ch_d = ch_q + CH_W'(1);
      end
      ST_SAT: begin
        if (acc_q > SAT_MAX) begin
          mix_d  = SAT_MAX[SAMPLE_W-1:0];
          clip_d = 1'b1;
        end else if (acc_q < SAT_MIN) begin
          mix_d  = SAT_MIN[SAMPLE_W-1:0];
          clip_d = 1'b1;
        end else begin
          mix_d = acc_q[SAMPLE_W-1:0];
        end
        if (mute_q) mix_d = '0;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ior_q   <= 1'b1;
      iow_q   <= 1'b1;
      iowp_q  <= 1'b1;
      idx_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) vol_q[i] <= VOL_UNITY;
      mute_q  <= 1'b0;
      clip_q  <= 1'b0;
      ovr_q   <= 1'b0;
      state_q <= ST_IDLE;
      ch_q    <= '0;
      acc_q   <= '0;
      buf_q   <= '0;
      mix_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ior_q   <= ior_d;
      iow_q   <= iow_d;
      iowp_q  <= iowp_d;
      idx_q   <= idx_d;
      vol_q   <= vol_d;
      mute_q  <= mute_d;
      clip_q  <= clip_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      buf_q   <= buf_d;
      mix_q   <= mix_d;
      valid_q <= valid_d;
    end
  end

  assign mix_out   = mix_q;
  assign mix_valid = valid_q;

  sigma_delta_dac #(
    .SAMPLE_W(SAMPLE_W)
  ) u_dac (
    .clk  (clk),
    .reset(reset),
    .din  (mix_q),
    .dout (dac_out)
  );

endmodule

// File: tb/tb_sound_mix_dac.sv
// Testbench for sound_mix_dac.
// Random and directed stimulus against a plain-arithmetic mix model.
module tb_sound_mix_dac;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 16;
  localparam int VOL_W    = 8;
  localparam logic [15:0] IO_IDX = 16'h038A;
  localparam logic [15:0] IO_DAT = 16'h038B;

  logic                       clk;
  logic                       reset;
  logic [19:0]                bus_a;
  logic                       bus_ior_l;
  logic                       bus_iow_l;
  logic                       bus_aen;
  logic [7:0]                 bus_d;
  logic [7:0]                 bus_out;
  logic                       bus_dir;
  logic [NUM_CH*SAMPLE_W-1:0] ch_in;
  logic                       sample_stb;
  logic [SAMPLE_W-1:0]        mix_out;
  logic                       mix_valid;
  logic                       dac_out;

  int n_checks;
  int n_fail;
  int vol_m [NUM_CH];
  bit mute_m;

  sound_mix_dac #(
    .NUM_CH  (NUM_CH),
    .SAMPLE_W(SAMPLE_W),
    .VOL_W   (VOL_W),
    .IO_BASE (16'h038A)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_a     (bus_a),
    .bus_ior_l (bus_ior_l),
    .bus_iow_l (bus_iow_l),
    .bus_aen   (bus_aen),
    .bus_d     (bus_d),
    .bus_out   (bus_out),
    .bus_dir   (bus_dir),
    .ch_in     (ch_in),
    .sample_stb(sample_stb),
    .mix_out   (mix_out),
    .mix_valid (mix_valid),
    .dac_out   (dac_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sum of floor(sample*vol/128), then clamp to 16-bit signed.
  function automatic logic [15:0] model_mix(input int s[NUM_CH],
                                            output bit clipped);
    longint sum;
    longint lim_hi;
    longint lim_lo;
    sum = 0;
    lim_hi = 32767;
    lim_lo = -32768;
    for (int i = 0; i < NUM_CH; i++)
      sum += (longint'(s[i]) * longint'(vol_m[i])) >>> (VOL_W - 1);
    clipped = 1'b0;
    if (sum > lim_hi) begin
      sum = lim_hi;
      clipped = 1'b1;
    end
    if (sum < lim_lo) begin
      sum = lim_lo;
      clipped = 1'b1;
    end
    if (mute_m) sum = 0;
    return 16'(sum);
  endfunction

  function automatic logic [NUM_CH*SAMPLE_W-1:0] pack(input int s[NUM_CH]);
    logic [NUM_CH*SAMPLE_W-1:0] p;
    for (int i = 0; i < NUM_CH; i++) p[i*SAMPLE_W +: SAMPLE_W] = 16'(s[i]);
    return p;
  endfunction

  task automatic io_write(input logic [15:0] a, input logic [7:0] d,
                          input logic aen);
    @(negedge clk);
    bus_a = {4'h0, a};
    bus_d = d;
    bus_aen = aen;
    bus_iow_l = 1'b0;
    repeat (3) @(negedge clk);
    bus_iow_l = 1'b1;
    repeat (2) @(negedge clk);
    bus_aen = 1'b0;
  endtask

  task automatic io_read(input logic [15:0] a, input logic aen,
                         output logic [7:0] d, output logic dir);
    @(negedge clk);
    bus_a = {4'h0, a};
    bus_aen = aen;
    bus_ior_l = 1'b0;
    repeat (2) @(negedge clk);
    d = bus_out;
    dir = bus_dir;
    bus_ior_l = 1'b1;
    bus_aen = 1'b0;
    @(negedge clk);
  endtask

  task automatic reg_write(input logic [7:0] idx, input logic [7:0] d);
    io_write(IO_IDX, idx, 1'b0);
    io_write(IO_DAT, d, 1'b0);
  endtask

  task automatic reg_read(input logic [7:0] idx, output logic [7:0] d);
    logic dir;
    io_write(IO_IDX, idx, 1'b0);
    io_read(IO_DAT, 1'b0, d, dir);
  endtask

  task automatic set_vol(input int ch, input int v);
    vol_m[ch] = v;
    reg_write(8'(ch), 8'(v));
  endtask

  // Strobe s1, optionally strobe s2 'gap' cycles later; record pulses.
  task automatic run_pair(input int s1[NUM_CH], input int s2[NUM_CH],
                          input int gap, output int npulse,
                          output int lat1, output logic [15:0] v1,
                          output int lat2, output logic [15:0] v2);
    npulse = 0;
    lat1 = -1;
    lat2 = -1;
    v1 = 'x;
    v2 = 'x;
    @(negedge clk);
    ch_in = pack(s1);
    sample_stb = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1 || c == gap + 1) sample_stb = 1'b0;
      if (mix_valid) begin
        npulse++;
        if (npulse == 1) begin
          lat1 = c;
          v1 = mix_out;
        end else begin
          lat2 = c - gap;
          v2 = mix_out;
        end
      end
      if (c == gap) begin
        ch_in = pack(s2);
        sample_stb = 1'b1;
      end
    end
  endtask

  task automatic run_mix(input int s[NUM_CH], output int lat,
                         output logic [15:0] v);
    int np;
    int l2;
    logic [15:0] x2;
    run_pair(s, s, 0, np, lat, v, l2, x2);
    n_checks++;
    if (np !== 1) begin
      n_fail++;
      $display("FAIL mix_pulse_count: got %0d want 1", np);
    end
  endtask

  task automatic count_dac(output int ones);
    ones = 0;
    repeat (20) @(negedge clk);
    repeat (1024) begin
      @(negedge clk);
      if (dac_out) ones++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic dir;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (mix_out !== 16'h0 || mix_valid !== 1'b0 || dac_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: mix_out=%h valid=%b dac=%b want 0",
               mix_out, mix_valid, dac_out);
    end
    n_checks++;
    if (bus_out !== 8'h00 || bus_dir !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus: bus_out=%h dir=%b want 00/0",
               bus_out, bus_dir);
    end
    reset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) vol_m[i] = 128;
    mute_m = 1'b0;
    io_read(IO_IDX, 1'b0, d, dir);
    n_checks++;
    if (d !== 8'h00 || dir !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idx: got %h dir=%b want 00 dir=1", d, dir);
    end
    reg_read(8'h00, d);
    n_checks++;
    if (d !== 8'h80) begin
      n_fail++;
      $display("FAIL reset_vol0: got %h want 80", d);
    end
    reg_read(8'h11, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_status: got %h want 00", d);
    end
    reg_read(8'h42, d);
    n_checks++;
    if (d !== 8'hFF) begin
      n_fail++;
      $display("FAIL unmapped_read: got %h want FF", d);
    end
    n_checks++;
    if (bus_out !== 8'h00 || bus_dir !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_bus: bus_out=%h dir=%b want 00/0",
               bus_out, bus_dir);
    end
  endtask

  task automatic test_unity_mix();
    int s[NUM_CH];
    int lat;
    logic [15:0] v;
    logic [15:0] exp_v;
    bit clp;
    s[0] = 1000;
    s[1] = 2000;
    s[2] = -500;
    s[3] = 0;
    exp_v = model_mix(s, clp);
    run_mix(s, lat, v);
    n_checks++;
    if (v !== exp_v || v !== 16'd2500) begin
      n_fail++;
      $display("FAIL unity_mix: got %0d want %0d", v, exp_v);
    end
    n_checks++;
    if (lat !== NUM_CH + 2) begin
      n_fail++;
      $display("FAIL unity_latency: got %0d want %0d", lat, NUM_CH + 2);
    end
  endtask

  task automatic test_clip();
    int s[NUM_CH];
    int lat;
    logic [15:0] v;
    logic [7:0] d;
    bit clp;
    for (int i = 0; i < NUM_CH; i++) set_vol(i, 255);
    for (int i = 0; i < NUM_CH; i++) s[i] = -28672;
    run_mix(s, lat, v);
    n_checks++;
    if (v !== 16'h8000) begin
      n_fail++;
      $display("FAIL clip_neg: got %h want 8000", v);
    end
    reg_write(8'h10, 8'h02);
    for (int i = 0; i < NUM_CH; i++) s[i] = 28672;
    run_mix(s, lat, v);
    n_checks++;
    if (v !== model_mix(s, clp) || v !== 16'h7FFF) begin
      n_fail++;
      $display("FAIL clip_pos: got %h want 7FFF", v);
    end
    reg_read(8'h11, d);
    n_checks++;
    if (d !== 8'h01) begin
      n_fail++;
      $display("FAIL clip_status: got %h want 01", d);
    end
    reg_write(8'h10, 8'h02);
    reg_read(8'h11, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL clip_clear: got %h want 00", d);
    end
    reg_read(8'h10, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL ctrl_readback: got %h want 00", d);
    end
  endtask

  task automatic test_dac_full();
    int ones;
    count_dac(ones);
    n_checks++;
    if (ones < 1022 || ones > 1024) begin
      n_fail++;
      $display("FAIL dac_full_density: got %0d want 1023+-1", ones);
    end
  endtask

  task automatic test_mute();
    int s[NUM_CH];
    int lat;
    int ones;
    logic [15:0] v;
    for (int i = 0; i < NUM_CH; i++) s[i] = 100 + 50 * i;
    reg_write(8'h10, 8'h01);
    mute_m = 1'b1;
    run_mix(s, lat, v);
    n_checks++;
    if (v !== 16'h0000 || lat !== NUM_CH + 2) begin
      n_fail++;
      $display("FAIL mute: got %h lat %0d want 0000 lat %0d",
               v, lat, NUM_CH + 2);
    end
    count_dac(ones);
    n_checks++;
    if (ones < 511 || ones > 513) begin
      n_fail++;
      $display("FAIL dac_half_density: got %0d want 512+-1", ones);
    end
    reg_write(8'h10, 8'h00);
    mute_m = 1'b0;
  endtask

  task automatic test_aen();
    logic [7:0] d;
    logic dir;
    io_write(IO_IDX, 8'h00, 1'b0);
    io_write(IO_DAT, 8'h11, 1'b1);
    io_read(IO_DAT, 1'b1, d, dir);
    n_checks++;
    if (dir !== 1'b0 || d !== 8'h00) begin
      n_fail++;
      $display("FAIL aen_read: got %h dir=%b want 00 dir=0", d, dir);
    end
    reg_read(8'h00, d);
    n_checks++;
    if (d !== 8'(vol_m[0])) begin
      n_fail++;
      $display("FAIL aen_write: vol0 got %h want %h", d, 8'(vol_m[0]));
    end
  endtask

  task automatic test_back_to_back();
    int s1[NUM_CH];
    int s2[NUM_CH];
    int gaps[3];
    int np;
    int l1;
    int l2;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [7:0] d;
    bit c1;
    bit c2;
    gaps[0] = 3;
    gaps[1] = NUM_CH + 1;
    gaps[2] = NUM_CH + 2;
    for (int i = 0; i < NUM_CH; i++) set_vol(i, $urandom_range(0, 200));
    foreach (gaps[g]) begin
      for (int i = 0; i < NUM_CH; i++) begin
        s1[i] = $urandom_range(0, 16000) - 8000;
        s2[i] = $urandom_range(0, 16000) - 8000;
      end
      e1 = model_mix(s1, c1);
      e2 = model_mix(s2, c2);
      reg_write(8'h10, 8'h02);
      run_pair(s1, s2, gaps[g], np, l1, v1, l2, v2);
      n_checks++;
      if (v1 !== e1 || l1 !== NUM_CH + 2) begin
        n_fail++;
        $display("FAIL b2b_first gap%0d: got %h lat %0d want %h lat %0d",
                 gaps[g], v1, l1, e1, NUM_CH + 2);
      end
      reg_read(8'h11, d);
      if (gaps[g] < NUM_CH + 2) begin
        n_checks++;
        if (np !== 1 || d !== {6'b0, 1'b1, c1}) begin
          n_fail++;
          $display("FAIL overrun gap%0d: pulses %0d status %h want 1 %h",
                   gaps[g], np, d, {6'b0, 1'b1, c1});
        end
      end else begin
        n_checks++;
        if (np !== 2 || v2 !== e2 || l2 !== NUM_CH + 2 ||
            d !== {6'b0, 1'b0, c1 | c2}) begin
          n_fail++;
          $display("FAIL spacing: pulses %0d v2 %h lat %0d st %h want 2 %h %0d %h",
                   np, v2, l2, d, e2, NUM_CH + 2, {6'b0, 1'b0, c1 | c2});
        end
      end
    end
  endtask

  task automatic test_random();
    int s[NUM_CH];
    int lat;
    logic [15:0] v;
    logic [15:0] e;
    logic [7:0] d;
    bit c;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NUM_CH; i++) set_vol(i, $urandom_range(0, 255));
      for (int i = 0; i < NUM_CH; i++) s[i] = $urandom_range(0, 65535) - 32768;
      e = model_mix(s, c);
      reg_write(8'h10, 8'h02);
      run_mix(s, lat, v);
      n_checks++;
      if (v !== e || lat !== NUM_CH + 2) begin
        n_fail++;
        $display("FAIL random_mix it%0d: got %h lat %0d want %h lat %0d",
                 it, v, lat, e, NUM_CH + 2);
      end
      reg_read(8'h11, d);
      n_checks++;
      if (d !== {7'b0, c}) begin
        n_fail++;
        $display("FAIL random_status it%0d: got %h want %h", it, d, {7'b0, c});
      end
    end
  endtask

  task automatic test_reset_mid_mix();
    int s[NUM_CH];
    int np;
    logic [7:0] d;
    for (int i = 0; i < NUM_CH; i++) s[i] = 5000;
    @(negedge clk);
    ch_in = pack(s);
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) vol_m[i] = 128;
    mute_m = 1'b0;
    np = 0;
    repeat (30) begin
      @(negedge clk);
      if (mix_valid) np++;
    end
    n_checks++;
    if (np !== 0 || mix_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_mix: pulses %0d mix_out %h want 0 0000",
               np, mix_out);
    end
    reg_read(8'h03, d);
    n_checks++;
    if (d !== 8'h80) begin
      n_fail++;
      $display("FAIL reset_mid_vol3: got %h want 80", d);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    bus_a = '0;
    bus_ior_l = 1'b1;
    bus_iow_l = 1'b1;
    bus_aen = 1'b0;
    bus_d = '0;
    ch_in = '0;
    sample_stb = 1'b0;
    mute_m = 1'b0;
    test_reset();
    test_unity_mix();
    test_clip();
    test_dac_full();
    test_mute();
    test_aen();
    test_back_to_back();
    test_random();
    test_reset_mid_mix();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
